uart_boot_loader: RTL and testbench

- Parametrised serial boot loader. Receives a UART byte stream (8N1) and detects a sync byte.
- Assembles bytes into WORD_W-bit words, big-endian: the first byte received lands in the MSB.
- Writes INST_DEPTH words to instruction memory, then DATA_DEPTH words to data memory, then raises start to release the core.
- Sits between the board rx pin and the core's inst/data memory write ports. It is the next-generation loader with configurable depths, word size, sync framing and error reporting.

---
 rtl/uart_boot_loader_pkg.sv | 34 +++
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 rtl/uart_boot_loader.sv | 217 +++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// The optional checksum trailer is enabled by UART_BOOT_LOADER_CKSUM_EN.
package uart_boot_loader_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      S_SYNC  = 3'd0,
      S_INST  = 3'd1,
      S_DATA  = 3'd2,
      S_CKSUM = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Serial receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Header byte that opens a load unless overridden
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // 8N1 framing
   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   // Address/counter width with a floor of one bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser plus history flop, baud counter
// and LSB-first shifter. Emits a one-cycle byte_vld or frame_err per frame.
module uart_rx_byte
   import uart_boot_loader_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_vld,
   output logic       o_frame_err
);

   localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
   localparam int CNT_W    = clog2_min1(BAUD_DIV);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic             r_rx_s1;
   logic             r_rx_s2;
   logic             r_rx_d;
   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_byte_vld;
   logic             r_frame_err;

   rx_state_t        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_bit_idx_nxt;
   logic [7:0]       w_shift_nxt;
   logic             w_byte_vld_nxt;
   logic             w_frame_err_nxt;

   // Synchronise rx into the clock domain and keep one sample of history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= i_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= RX_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_byte_vld  <= w_byte_vld_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // Frame sequencing: start re-check at mid-bit, then one sample per bit period
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt + 1'b1;
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_byte_vld_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nxt = '0;
            if (r_rx_d && !r_rx_s2) begin
               w_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (r_cnt == HALF_CNT) begin
               w_cnt_nxt     = '0;
               w_bit_idx_nxt = '0;
               // A line that is high again at mid-start was only a glitch
               w_state_nxt   = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt == FULL_CNT) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_rx_s2, r_shift[7:1]};
               if (r_bit_idx == LAST_BIT) begin
                  w_state_nxt = RX_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (r_cnt == FULL_CNT) begin
               w_cnt_nxt       = '0;
               w_state_nxt     = RX_IDLE;
               w_byte_vld_nxt  = r_rx_s2;
               w_frame_err_nxt = !r_rx_s2;
            end
         end
         default: begin
            w_state_nxt = RX_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_byte      = r_shift;
   assign o_byte_vld  = r_byte_vld;
   assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: waits for a sync byte, assembles big-endian words and
// writes INST_DEPTH instruction words then DATA_DEPTH data words, then raises
// start. Define UART_BOOT_LOADER_CKSUM_EN to require a trailing 8-bit sum byte.
// Handshake: inst_we/data_we are single-cycle strobes with no back-pressure;
// wdata and the matching address are valid only in the strobe cycle.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int         CLK_FREQ   = 50000000,
   parameter int         UART_BPS   = 115200,
   parameter int         WORD_BYTES = 4,
   parameter int         INST_DEPTH = 64,
   parameter int         DATA_DEPTH = 32,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
   localparam int        WORD_W     = 8 * WORD_BYTES,
   localparam int        IADDR_W    = clog2_min1(INST_DEPTH),
   localparam int        DADDR_W    = clog2_min1(DATA_DEPTH)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               rx,
   output logic               inst_we,
   output logic [IADDR_W-1:0] inst_addr,
   output logic               data_we,
   output logic [DADDR_W-1:0] data_addr,
   output logic [WORD_W-1:0]  wdata,
   output logic               busy,
   output logic               err,
   output logic               start,
   output state_t             dbg_state
);

   localparam int                 BCNT_W     = clog2_min1(WORD_BYTES);
   localparam logic [BCNT_W-1:0]  LAST_BYTE  = BCNT_W'(WORD_BYTES - 1);
   localparam logic [IADDR_W-1:0] LAST_IADDR = IADDR_W'(INST_DEPTH - 1);
   localparam logic [DADDR_W-1:0] LAST_DADDR = DADDR_W'(DATA_DEPTH - 1);

   logic [7:0]         w_byte;
   logic               w_byte_vld;
   logic               w_frame_err;
   logic [WORD_W-1:0]  w_shift_nxt;
   logic               w_sync_hit;
   state_t             w_state_nxt;

   state_t             r_state;
   logic [WORD_W-1:0]  r_shift;
   logic [BCNT_W-1:0]  r_byte_cnt;
   logic [IADDR_W-1:0] r_iaddr;
   logic [DADDR_W-1:0] r_daddr;
   logic               r_inst_we;
   logic               r_data_we;
   logic [WORD_W-1:0]  r_wdata;
   logic               r_err;
`ifdef UART_BOOT_LOADER_CKSUM_EN
   logic [7:0]         r_sum;
   logic               w_cksum_ok;
`endif

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) u_rx (
      .i_clk       (sys_clk),
      .i_rst       (sys_rst),
      .i_rx        (rx),
      .o_byte      (w_byte),
      .o_byte_vld  (w_byte_vld),
      .o_frame_err (w_frame_err)
   );

   assign w_shift_nxt = (r_shift << 8) | WORD_W'(w_byte);
   assign w_sync_hit  = w_byte_vld && (w_byte == SYNC_BYTE);
`ifdef UART_BOOT_LOADER_CKSUM_EN
   assign w_cksum_ok  = (w_byte == r_sum);
`endif

   // Loader state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= S_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: phase changes happen in the strobe cycle of the last word
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SYNC: begin
            if (w_sync_hit) begin
               w_state_nxt = S_INST;
            end
         end
         S_INST: begin
            if (w_frame_err) begin
               w_state_nxt = S_SYNC;
            end else if (r_inst_we && (r_iaddr == LAST_IADDR)) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_frame_err) begin
               w_state_nxt = S_SYNC;
            end else if (r_data_we && (r_daddr == LAST_DADDR)) begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
               w_state_nxt = S_CKSUM;
`else
               w_state_nxt = S_DONE;
`endif
            end
         end
         S_CKSUM: begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
            if (w_frame_err) begin
               w_state_nxt = S_SYNC;
            end else if (w_byte_vld) begin
               w_state_nxt = w_cksum_ok ? S_DONE : S_SYNC;
            end
`else
            w_state_nxt = S_SYNC;
`endif
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: begin
            w_state_nxt = S_SYNC;
         end
      endcase
   end

   // Word assembly, write strobes, address counters and sticky error
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_shift    <= '0;
         r_byte_cnt <= '0;
         r_iaddr    <= '0;
         r_daddr    <= '0;
         r_inst_we  <= 1'b0;
         r_data_we  <= 1'b0;
         r_wdata    <= '0;
         r_err      <= 1'b0;
`ifdef UART_BOOT_LOADER_CKSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         r_inst_we <= 1'b0;
         r_data_we <= 1'b0;
         r_wdata   <= '0;
         // Word counters advance once their strobe has been presented
         if (r_inst_we) begin
            r_iaddr <= r_iaddr + 1'b1;
         end
         if (r_data_we) begin
            r_daddr <= r_daddr + 1'b1;
         end
         case (r_state)
            S_SYNC: begin
               if (w_sync_hit) begin
                  r_shift    <= '0;
                  r_byte_cnt <= '0;
                  r_iaddr    <= '0;
                  r_daddr    <= '0;
`ifdef UART_BOOT_LOADER_CKSUM_EN
                  r_sum      <= '0;
`endif
               end
            end
            S_INST, S_DATA: begin
               if (w_frame_err) begin
                  // Drop the partial word; memory already written stays as is
                  r_err      <= 1'b1;
                  r_shift    <= '0;
                  r_byte_cnt <= '0;
                  r_iaddr    <= '0;
                  r_daddr    <= '0;
               end else if (w_byte_vld) begin
                  r_shift <= w_shift_nxt;
`ifdef UART_BOOT_LOADER_CKSUM_EN
                  r_sum   <= r_sum + w_byte;
`endif
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_byte_cnt <= '0;
                     r_wdata    <= w_shift_nxt;
                     r_inst_we  <= (r_state == S_INST);
                     r_data_we  <= (r_state == S_DATA);
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end
            S_CKSUM: begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
               if (w_frame_err || (w_byte_vld && !w_cksum_ok)) begin
                  r_err <= 1'b1;
               end
`endif
            end
            default: begin
               r_shift <= r_shift;
            end
         endcase
      end
   end

   assign inst_we   = r_inst_we;
   assign data_we   = r_data_we;
   assign inst_addr = r_iaddr;
   assign data_addr = r_daddr;
   assign wdata     = r_wdata;
   assign err       = r_err;
   assign busy      = (r_state == S_INST) || (r_state == S_DATA) || (r_state == S_CKSUM);
   assign start     = (r_state == S_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader (10 clocks per bit, 4x4-byte inst
// words, 2 data words). Write strobes are checked against an expected queue.
`timescale 1ns/1ps
module tb_uart_boot_loader;
   import uart_boot_loader_pkg::*;

   localparam int CLK_FREQ   = 1000000;
   localparam int UART_BPS   = 100000;
   localparam int BAUD_DIV   = CLK_FREQ / UART_BPS;
   localparam int WORD_BYTES = 4;
   localparam int INST_DEPTH = 4;
   localparam int DATA_DEPTH = 2;
   localparam int NBYTES     = WORD_BYTES * (INST_DEPTH + DATA_DEPTH);

   logic        sys_clk;
   logic        sys_rst;
   logic        rx;
   logic        inst_we;
   logic [1:0]  inst_addr;
   logic        data_we;
   logic [0:0]  data_addr;
   logic [31:0] wdata;
   logic        busy;
   logic        err;
   logic        start;
   state_t      dbg_state;

   int checks = 0;
   int errors = 0;
   logic [40:0] exp_q[$];

   uart_boot_loader #(
      .CLK_FREQ   (CLK_FREQ),
      .UART_BPS   (UART_BPS),
      .WORD_BYTES (WORD_BYTES),
      .INST_DEPTH (INST_DEPTH),
      .DATA_DEPTH (DATA_DEPTH),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .rx        (rx),
      .inst_we   (inst_we),
      .inst_addr (inst_addr),
      .data_we   (data_we),
      .data_addr (data_addr),
      .wdata     (wdata),
      .busy      (busy),
      .err       (err),
      .start     (start),
      .dbg_state (dbg_state)
   );

   // Clock and watchdog
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   // Scoreboard: every strobe must match the next expected {is_data, addr, word}
   always @(negedge sys_clk) begin
      logic [40:0] act;
      logic [40:0] exp;
      if (inst_we === 1'b1 || data_we === 1'b1) begin
         act = {data_we, (data_we === 1'b1) ? {7'd0, data_addr} : {6'd0, inst_addr}, wdata};
         checks++;
         if (inst_we === 1'b1 && data_we === 1'b1) begin
            errors++;
            $display("FAIL strobe_both: inst_we and data_we high together, got %h", act);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got %h, expected no write", act);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               errors++;
               $display("FAIL strobe: got %h, expected %h", act, exp);
            end
         end
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(BAUD_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BAUD_DIV);
      end
      rx = stop_bit;
      tick(BAUD_DIV);
      rx = 1'b1;
      tick(BAUD_DIV);
   endtask

   // Payload byte i has value i; the expected word is queued before its last byte
   task automatic send_payload(input int lo, input int hi);
      int k;
      logic [31:0] w;
      for (int i = lo; i <= hi; i++) begin
         if (i % WORD_BYTES == WORD_BYTES - 1) begin
            k = i / WORD_BYTES;
            w = {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)};
            if (k < INST_DEPTH) exp_q.push_back({1'b0, 8'(k), w});
            else                exp_q.push_back({1'b1, 8'(k - INST_DEPTH), w});
         end
         send_byte(8'(i), 1'b1);
      end
   endtask

   function automatic logic [7:0] payload_sum();
      logic [7:0] s = 8'd0;
      for (int i = 0; i < NBYTES; i++) s = s + 8'(i);
      return s;
   endfunction

   task automatic send_stream(input bit with_sync);
      if (with_sync) send_byte(8'hA5, 1'b1);
      send_payload(0, NBYTES - 1);
`ifdef UART_BOOT_LOADER_CKSUM_EN
      send_byte(payload_sum(), 1'b1);
`endif
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (start !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      checks++;
      if (start !== 1'b1) begin
         errors++;
         $display("FAIL %s_start: start=%b after %0d cycles, expected 1", name, start, n);
      end
   endtask

   task automatic check_done(input string name, input logic exp_err);
      wait_start(name);
      checks++;
      if (err !== exp_err || busy !== 1'b0 || dbg_state !== S_DONE) begin
         errors++;
         $display("FAIL %s_done: err=%b busy=%b state=%0d, expected err=%b busy=0 state=%0d",
                  name, err, busy, dbg_state, exp_err, S_DONE);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_writes: %0d expected writes missing, expected 0", name, exp_q.size());
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [39:0] o;
      o = {inst_we, inst_addr, data_we, data_addr, wdata, busy, err, start};
      checks++;
      if (o !== 40'd0 || dbg_state !== S_SYNC) begin
         errors++;
         $display("FAIL %s: outputs=%h state=%0d, expected outputs=0 state=%0d", name, o, dbg_state, S_SYNC);
      end
   endtask

   // Scenario tasks
   task automatic test_reset();
      sys_rst = 1'b1;
      rx      = 1'b1;
      tick(3);
      check_all_zero("reset_state");
      sys_rst = 1'b0;
      tick(2);
      check_all_zero("reset_idle");
   endtask

   task automatic test_basic_load();
      do_reset();
      send_stream(1'b1);
      check_done("basic", 1'b0);
   endtask

   task automatic test_sync_hunt();
      do_reset();
      send_byte(8'h3C, 1'b1);
      send_byte(8'h5A, 1'b1);
      checks++;
      if (busy !== 1'b0 || dbg_state !== S_SYNC) begin
         errors++;
         $display("FAIL hunt_idle: busy=%b state=%0d, expected busy=0 state=%0d", busy, dbg_state, S_SYNC);
      end
      send_stream(1'b1);
      check_done("hunt", 1'b0);
   endtask

   task automatic test_frame_err();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_payload(0, 5);
      send_byte(8'h06, 1'b0);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || dbg_state !== S_SYNC || start !== 1'b0) begin
         errors++;
         $display("FAIL ferr_abort: err=%b busy=%b start=%b state=%0d, expected err=1 busy=0 start=0 state=%0d",
                  err, busy, start, dbg_state, S_SYNC);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL ferr_partial: %0d expected writes missing, expected 0", exp_q.size());
      end
      send_stream(1'b1);
      check_done("ferr_reload", 1'b1);
   endtask

   task automatic test_glitch();
      do_reset();
      send_byte(8'hA5, 1'b1);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(3 * BAUD_DIV);
      checks++;
      if (err !== 1'b0 || dbg_state !== S_INST) begin
         errors++;
         $display("FAIL glitch: err=%b state=%0d, expected err=0 state=%0d", err, dbg_state, S_INST);
      end
      send_stream(1'b0);
      check_done("glitch", 1'b0);
   endtask

   task automatic test_reset_mid_data();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_payload(0, WORD_BYTES * INST_DEPTH + 1);
      checks++;
      if (busy !== 1'b1 || dbg_state !== S_DATA) begin
         errors++;
         $display("FAIL rst_mid_pre: busy=%b state=%0d, expected busy=1 state=%0d", busy, dbg_state, S_DATA);
      end
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      check_all_zero("rst_mid_zero");
      send_stream(1'b1);
      check_done("rst_mid", 1'b0);
   endtask

`ifdef UART_BOOT_LOADER_CKSUM_EN
   task automatic test_cksum_bad();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_payload(0, NBYTES - 1);
      send_byte(payload_sum() + 8'd1, 1'b1);
      checks++;
      if (err !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || dbg_state !== S_SYNC) begin
         errors++;
         $display("FAIL cksum_bad: err=%b start=%b busy=%b state=%0d, expected err=1 start=0 busy=0 state=%0d",
                  err, start, busy, dbg_state, S_SYNC);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL cksum_writes: %0d expected writes missing, expected 0", exp_q.size());
      end
   endtask
`endif

   task automatic test_back_to_back();
      do_reset();
      send_stream(1'b1);
      check_done("b2b_first", 1'b0);
      // Traffic after completion must produce nothing
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      checks++;
      if (start !== 1'b1 || err !== 1'b0 || dbg_state !== S_DONE) begin
         errors++;
         $display("FAIL b2b_ignore: start=%b err=%b state=%0d, expected start=1 err=0 state=%0d",
                  start, err, dbg_state, S_DONE);
      end
   endtask

   // Test sequence and final report
   initial begin
      sys_rst = 1'b1;
      rx      = 1'b1;
      @(negedge sys_clk);
      test_reset();
      test_basic_load();
      test_sync_hunt();
      test_frame_err();
      test_glitch();
      test_reset_mid_data();
`ifdef UART_BOOT_LOADER_CKSUM_EN
      test_cksum_bad();
`endif
      test_back_to_back();
      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
